// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer with sub-word extension and read-modify-write for byte/halfword stores
module mem_access_ctrl #(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t      state;
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic        bad;
    logic [31:0] addr_al;
    logic [4:0]  boff;
    logic [4:0]  hoff;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign mem_adr = {addr_q[31:2], 2'b00};

    // request classification, alignment forcing, load lane extension and store lane merge
    always_comb begin
        bad      = size == 2'b11 || (ALIGN_CHECK != 0 &&
                   ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)));
        addr_al  = (ALIGN_CHECK != 0) ? addr
                 : {addr[31:2], size[1] ? 2'b00 : {addr[1], addr[0] & ~size[0]}};
        boff     = {addr_q[1:0], 3'b000};
        hoff     = {addr_q[1], 4'b0000};
        byte_sh  = mem_dout >> boff;
        half_sh  = mem_dout >> hoff;
        load_val = size_q == 2'b00 ? {{24{sign_q & byte_sh[7]}}, byte_sh[7:0]}
                 : size_q == 2'b01 ? {{16{sign_q & half_sh[15]}}, half_sh[15:0]}
                 : mem_dout;
        merged   = size_q == 2'b00
                 ? (mem_dout & ~(32'h0000_00FF << boff)) | ({24'd0, wdata_q[7:0]} << boff)
                 : (mem_dout & ~(32'h0000_FFFF << hoff)) | ({16'd0, wdata_q} << hoff);
    end

    // access sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            mem_din <= 32'd0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q    <= we;
                    sign_q  <= sign_ext;
                    size_q  <= size;
                    addr_q  <= addr_al;
                    wdata_q <= wdata[15:0];
                    busy    <= 1'b1;
                    if (bad) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (we && size == 2'b10) begin
                        state   <= WR;
                        mem_wr  <= 1'b1;
                        mem_din <= wdata;
                    end else begin
                        state  <= RD;
                        mem_rd <= 1'b1;
                    end
                end
                RD: begin
                    mem_rd <= 1'b0;
                    if (we_q) begin
                        state   <= WR;
                        mem_wr  <= 1'b1;
                        mem_din <= merged;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        rdata <= load_val;
                    end
                end
                WR: begin
                    state   <= DONE;
                    mem_wr  <= 1'b0;
                    mem_din <= 32'd0;
                    done    <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table, corner-case sequences and randomized accesses against a byte-array reference
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req2 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err, mem_rd, mem_wr;
    logic [31:0] rdata, mem_adr, mem_din, mem_dout;
    logic        busy2, done2, err2, mem_rd2, mem_wr2;
    logic [31:0] rdata2, mem_adr2, mem_din2, mem_dout2;
    logic [31:0] mem [1024] = '{default: 32'd0};
    logic [7:0]  ref_mem [4096];
    logic [31:0] exp_rdata = 32'd0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        e;
        logic [31:0] rdata;
        logic [31:0] memw;
    } vec_t;
    vec_t tv [9];

    mem_access_ctrl #(.ALIGN_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_adr(mem_adr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout)
    );

    mem_access_ctrl #(.ALIGN_CHECK(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy2), .done(done2), .err(err2), .rdata(rdata2),
        .mem_adr(mem_adr2), .mem_din(mem_din2), .mem_rd(mem_rd2), .mem_wr(mem_wr2), .mem_dout(mem_dout2)
    );

    always #5 clk = ~clk;

    assign mem_dout  = mem[mem_adr[11:2]];
    assign mem_dout2 = (mem_adr2 == 32'h7D0) ? 32'h1234_5678 : 32'd0;

    always @(posedge clk) if (mem_wr) mem[mem_adr[11:2]] <= mem_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_word(input int b);
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        int n = 1 << sz;
        int b = int'(a[11:0]) & ~(n - 1);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[b + i];
        if (sx && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic access(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic e, output logic rs,
                          output logic ws, output logic [31:0] din);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; e = 1'b0; rs = 1'b0; ws = 1'b0; din = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rs |= mem_rd;
            ws |= mem_wr;
            if (mem_wr) din = mem_din;
            if (done) begin
                lat = k;
                e = err;
                break;
            end
            chk("err_without_done", {31'd0, err}, 32'd0);
        end
    endtask

    task automatic apply(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] d, input string tag, output int lat, output logic e);
        logic re = ref_err(sz, a);
        int n = 1 << sz;
        int b = int'(a[11:0]) & ~(n - 1);
        int wl = re ? 1 : (!w || sz == 2'b10) ? 2 : 3;
        logic rs, ws;
        logic [31:0] din;
        access(w, sz, sx, a, d, lat, e, rs, ws, din);
        if (!re && !w) exp_rdata = ref_load(sz, sx, a);
        if (!re && w) for (int i = 0; i < n; i++) ref_mem[b + i] = d[8*i +: 8];
        chk({tag, " latency"}, 32'(lat), 32'(wl));
        chk({tag, " err"}, {31'd0, e}, {31'd0, re});
        chk({tag, " rdata"}, rdata, exp_rdata);
        chk({tag, " mem_rd_seen"}, {31'd0, rs}, {31'd0, !re && !(w && sz == 2'b10)});
        chk({tag, " mem_wr_seen"}, {31'd0, ws}, {31'd0, !re && w});
        if (!re && w) begin
            chk({tag, " mem_din"}, din, ref_word(b & ~3));
            chk({tag, " mem_word"}, mem[(b & ~3) >> 2], ref_word(b & ~3));
        end
    endtask

    initial begin
        int lat;
        logic e;
        int nd;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        tv[0] = '{1'b1, 2'd2, 1'b0, 32'h7D0, 32'hDEADBEEF, 2, 1'b0, 32'h0000_0000, 32'hDEADBEEF};
        tv[1] = '{1'b0, 2'd2, 1'b0, 32'h7D0, 32'h0,        2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tv[2] = '{1'b1, 2'd0, 1'b0, 32'h7D1, 32'h5A,       3, 1'b0, 32'hDEADBEEF, 32'hDEAD5AEF};
        tv[3] = '{1'b0, 2'd0, 1'b1, 32'h7D3, 32'h0,        2, 1'b0, 32'hFFFFFFDE, 32'hDEAD5AEF};
        tv[4] = '{1'b0, 2'd0, 1'b0, 32'h7D3, 32'h0,        2, 1'b0, 32'h000000DE, 32'hDEAD5AEF};
        tv[5] = '{1'b0, 2'd1, 1'b1, 32'h7D2, 32'h0,        2, 1'b0, 32'hFFFFDEAD, 32'hDEAD5AEF};
        tv[6] = '{1'b0, 2'd0, 1'b1, 32'h7D1, 32'h0,        2, 1'b0, 32'h0000005A, 32'hDEAD5AEF};
        tv[7] = '{1'b0, 2'd2, 1'b0, 32'h7D2, 32'h0,        1, 1'b1, 32'h0000005A, 32'hDEAD5AEF};
        tv[8] = '{1'b0, 2'd3, 1'b0, 32'h7D0, 32'h0,        1, 1'b1, 32'h0000005A, 32'hDEAD5AEF};

        #2;
        chk("reset ctrl", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mem_adr", mem_adr, 32'd0);
        chk("reset mem_din", mem_din, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(tv[i].w, tv[i].sz, tv[i].sx, tv[i].a, tv[i].d, $sformatf("vec%0d", i), lat, e);
            chk($sformatf("vec%0d table latency", i), 32'(lat), 32'(tv[i].lat));
            chk($sformatf("vec%0d table err", i), {31'd0, e}, {31'd0, tv[i].e});
            chk($sformatf("vec%0d table rdata", i), rdata, tv[i].rdata);
            chk($sformatf("vec%0d table mem", i), mem[500], tv[i].memw);
        end

        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h7D0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("ignore busy", {31'd0, busy}, 32'd1);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h7D0; wdata = 32'h0;
        @(posedge clk);
        #1 req = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        exp_rdata = ref_load(2'd2, 1'b0, 32'h7D0);
        chk("ignore done_count", 32'(nd), 32'd1);
        chk("ignore mem", mem[500], 32'hDEAD5AEF);
        chk("ignore rdata", rdata, 32'hDEAD5AEF);

        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h7D2; wdata = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rstwr rd", {31'd0, mem_rd}, 32'd1);
        @(negedge clk);
        chk("rstwr wr", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwr async", {28'd0, mem_wr, mem_rd, busy, done}, 32'd0);
        chk("rstwr mem_din", mem_din, 32'd0);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rstwr no_done", 32'(nd), 32'd0);
        chk("rstwr mem", mem[500], 32'hDEAD5AEF);
        rst_n = 1'b1;
        exp_rdata = 32'd0;
        apply(1'b0, 2'd2, 1'b0, 32'h7D0, 32'h0, "post_rst_load", lat, e);
        chk("post_rst rdata", rdata, 32'hDEAD5AEF);

        @(negedge clk);
        req2 = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h7D2;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        chk("noalign rd", {30'd0, mem_rd2, mem_wr2}, 32'd2);
        chk("noalign adr", mem_adr2, 32'h7D0);
        @(negedge clk);
        chk("noalign done", {30'd0, done2, err2}, 32'd2);
        chk("noalign rdata", rdata2, 32'h1234_5678);
        chk("noalign din", mem_din2, 32'd0);
        @(negedge clk);
        req2 = 1'b1; we = 1'b0; size = 2'd1; sign_ext = 1'b1; addr = 32'h7D3;
        @(posedge clk);
        #1 req2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("noalign half done", {30'd0, done2, err2}, 32'd2);
        chk("noalign half rdata", rdata2, 32'h0000_1234);

        for (int i = 0; i < 80; i++)
            apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h700 + 32'($urandom_range(0, 255)), $urandom, $sformatf("rnd%0d", i), lat, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
